vreg_change_monitor: RTL and testbench
======================================

Name: vreg_change_monitor

Overview:
- Sits directly downstream of the vreg test top; consumes a watched register (e.g. a_sub_vreg, 56 bits) sampled on clk.
- Detects value changes, timestamps each with a free-running cycle count and buffers them in a first-word-fall-through FIFO.
- The Teal C++ side drains the FIFO through a valid/ready port using vregs, so it can check change history without relying on $display output.

Parameters:
- WIDTH, 56, width of watched data.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TS_WIDTH, 32, timestamp/cycle counter width.

Ports:
- clk  input  1  sampling clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  monitoring enable, typically tied to init_done.
- watch_data  input  WIDTH  register under observation.
- out_ready  input  1  consumer accepts head entry.
- out_valid  output  1  FIFO non-empty.
- out_data  output  WIDTH  head entry value.
- out_timestamp  output  TS_WIDTH  cycle count at which the head entry's change was sampled.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- overflow_count  output  8  dropped events, saturating.

Behaviour:
- Reset (async on reset_n low, released synchronously to clk):
  - cycle counter = 0, prev = 0, state = IDLE, FIFO empty.
  - out_valid = 0, out_data = 0, out_timestamp = 0, fifo_level = 0, overflow_count = 0.
- Cycle counter:
  - Increments by 1 every clk after reset, independent of enable.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- State machine, one transition per clk:
  - IDLE: no sampling. enable=1 goes to ARM.
  - ARM: prev <= watch_data (baseline); no event pushed. enable=1 goes to WATCH; enable=0 returns to IDLE.
  - WATCH: if watch_data != prev, push {watch_data, counter} and set prev <= watch_data. enable=0 goes to IDLE.
- A change coinciding with enable falling in WATCH is still pushed in that cycle.
- Push latency: the change is sampled at edge N. The entry is visible at out_valid/out_data after edge N, i.e. the next cycle. The timestamp equals the counter value before edge N.
- Pop handshake:
  - An entry is consumed when out_valid && out_ready at a clk edge.
  - out_data and out_timestamp hold stable while out_valid=1 and out_ready=0.
- Full/empty:
  - Push when full with no pop: event dropped, overflow_count += 1, saturating at 255. prev is still updated.
  - Push and pop in the same cycle when full: both occur, level unchanged, no drop.
  - Pop when empty: ignored.
  - Push and pop in the same cycle when empty: the entry appears next cycle; a same-cycle bypass is not allowed.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- Leaving WATCH, or reset mid-operation:
  - enable deassertion keeps FIFO contents; the consumer may drain while IDLE.
  - Re-enable passes through ARM, so a new baseline is taken and no spurious event occurs.
  - reset_n low mid-operation clears everything immediately, including pending entries.

Optional Feature:
- Macro: VREG_MON_FIRST_SAMPLE_EN.
- Defined: in ARM, the baseline value is also pushed as an event (timestamp = counter), subject to the same full/overflow rules.
- Undefined: ARM only captures the baseline; the first event is the first true change.

Test Plan:
- Reset then enable=1, watch_data held at 56'h234567891200 for 20 cycles -> out_valid stays 0 and fifo_level=0. With VREG_MON_FIRST_SAMPLE_EN, exactly one entry 56'h234567891200 appears.
- Enable at cycle 5, watch_data changes to 56'h1 at cycle 10 and to 56'h2 at cycle 13, out_ready=1 -> two entries in order (56'h1, ts=10) then (56'h2, ts=13), each valid one cycle after the change.
- out_ready=0, 10 consecutive changes with DEPTH=8 -> fifo_level=8, overflow_count=2. Draining yields the first 8 values in order.
- FIFO full, change and pop in the same cycle -> level stays 8, overflow_count unchanged, new value appears at the tail.
- 4 entries queued, enable=0, watch_data toggled 3 times -> no new entries. Drain returns the 4 originals. Re-enable with no change -> no entry.
- reset_n pulsed low asynchronously between edges with 5 entries queued -> out_valid=0, fifo_level=0 and overflow_count=0 immediately. Counter restarts at 0.

Source files
------------

// File: rtl/vreg_change_monitor_if.sv
// Valid/ready drain port of the vreg change monitor: head entry value plus the cycle
// stamp at which that change was sampled.
interface vreg_change_monitor_if #(
  parameter int WIDTH    = 56,
  parameter int TS_WIDTH = 32
);
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [TS_WIDTH-1:0] out_timestamp;

  modport master (
    output out_valid,
    output out_data,
    output out_timestamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_timestamp,
    output out_ready
  );
endinterface

// File: rtl/vreg_change_monitor.sv
// Timestamps value changes of a watched vreg and queues them in a first-word-fall-through FIFO.
// Optional build macro VREG_MON_FIRST_SAMPLE_EN also logs the baseline captured on arming.
module vreg_change_monitor #(
  parameter int WIDTH    = 56,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       watch_data,
  vreg_change_monitor_if.master  out_if,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             overflow_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WATCH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] cycleCnt_q;
  logic [WIDTH-1:0]    prev_q, prev_d;

  logic [WIDTH-1:0]    dataMem_q [DEPTH];
  logic [TS_WIDTH-1:0] tsMem_q   [DEPTH];
  logic [AW-1:0]       wrPtr_q, wrPtr_d;
  logic [AW-1:0]       rdPtr_q, rdPtr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [7:0]          ovfCnt_q, ovfCnt_d;

  logic pushReq;
  logic fifoEmpty;
  logic fifoFull;
  logic popFire;
  logic pushAccept;
  logic pushDrop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_q + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // A change sampled in WATCH is pushed even when enable drops in the same cycle.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pushReq = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ARM;
        end
      end
      ARM: begin
        prev_d = watch_data;
`ifdef VREG_MON_FIRST_SAMPLE_EN
        pushReq = 1'b1;
`else
        pushReq = 1'b0;
`endif
        state_d = enable ? WATCH : IDLE;
      end
      WATCH: begin
        if (watch_data != prev_q) begin
          pushReq = 1'b1;
          prev_d  = watch_data;
        end
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A pop frees the slot a same-cycle push needs, so a full FIFO only drops when not draining.
  always_comb begin
    fifoEmpty  = (level_q == '0);
    fifoFull   = (level_q == LW'(DEPTH));
    popFire    = !fifoEmpty && out_if.out_ready;
    pushAccept = pushReq && (!fifoFull || popFire);
    pushDrop   = pushReq && fifoFull && !popFire;

    wrPtr_d  = pushAccept ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d  = popFire ? rdPtr_q + AW'(1) : rdPtr_q;

    level_d = level_q;
    if (pushAccept && !popFire) begin
      level_d = level_q + LW'(1);
    end else if (!pushAccept && popFire) begin
      level_d = level_q - LW'(1);
    end

    ovfCnt_d = ovfCnt_q;
    if (pushDrop && (ovfCnt_q != 8'hFF)) begin
      ovfCnt_d = ovfCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      ovfCnt_q <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      ovfCnt_q <= ovfCnt_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the occupancy says it is valid.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      dataMem_q[wrPtr_q] <= watch_data;
      tsMem_q[wrPtr_q]   <= cycleCnt_q;
    end
  end

  assign out_if.out_valid     = !fifoEmpty;
  assign out_if.out_data      = fifoEmpty ? '0 : dataMem_q[rdPtr_q];
  assign out_if.out_timestamp = fifoEmpty ? '0 : tsMem_q[rdPtr_q];
  assign fifo_level           = level_q;
  assign overflow_count       = ovfCnt_q;

  levelBound: assert property (@(posedge clk) disable iff (!reset_n)
    level_q <= LW'(DEPTH));

  headStableWhileStalled: assert property (@(posedge clk) disable iff (!reset_n)
    (out_if.out_valid && !out_if.out_ready) |=>
      ($stable(out_if.out_data) && $stable(out_if.out_timestamp)));

endmodule

// File: tb/tb_vreg_change_monitor.sv
// Scoreboard bench for vreg_change_monitor: a sample-history reference model queues expected
// entries, a negedge monitor compares and retires them as the consumer drains the FIFO.
module tb_vreg_change_monitor;
  localparam int WIDTH    = 56;
  localparam int DEPTH    = 8;
  localparam int TS_WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  logic                   clk       = 1'b0;
  logic                   reset_n   = 1'b1;
  logic                   enable    = 1'b0;
  logic [WIDTH-1:0]       watchData = '0;
  logic [$clog2(DEPTH):0] fifoLevel;
  logic [7:0]             overflowCount;

  vreg_change_monitor_if #(.WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH)) monIf ();

  vreg_change_monitor #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TS_WIDTH(TS_WIDTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .watch_data    (watchData),
    .out_if        (monIf),
    .fifo_level    (fifoLevel),
    .overflow_count(overflowCount)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  entry_t           expQ[$];
  entry_t           popLog[$];
  int               modelLevel = 0;
  int               modelOvf   = 0;
  logic [TS_WIDTH-1:0] tbCycle = '0;
  logic             enHist1    = 1'b0;
  logic             enHist2    = 1'b0;
  logic [WIDTH-1:0] lastSample = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: the monitor is watching when enable was seen on both previous edges, and a
  // change means the current sample differs from the one taken on the previous edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expQ.delete();
      modelLevel <= 0;
      modelOvf   <= 0;
      tbCycle    <= '0;
      enHist1    <= 1'b0;
      enHist2    <= 1'b0;
      lastSample <= '0;
    end else begin : modelStep
      logic evt;
      int   lvl;
      int   ovf;
      evt = enHist1 && enHist2 && (watchData != lastSample);
`ifdef VREG_MON_FIRST_SAMPLE_EN
      if (enHist1 && !enHist2) evt = 1'b1;
`endif
      lvl = modelLevel;
      ovf = modelOvf;
      if (lvl > 0 && monIf.out_ready) lvl = lvl - 1;
      if (evt) begin
        if (lvl < DEPTH) begin
          expQ.push_back({watchData, tbCycle});
          lvl = lvl + 1;
        end else if (ovf < 255) begin
          ovf = ovf + 1;
        end
      end
      modelLevel <= lvl;
      modelOvf   <= ovf;
      lastSample <= watchData;
      enHist2    <= enHist1;
      enHist1    <= enable;
      tbCycle    <= tbCycle + TS_WIDTH'(1);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("fifo_level", 64'(fifoLevel), 64'(modelLevel));
      checkOutput("overflow_count", 64'(overflowCount), 64'(modelOvf));
      checkOutput("out_valid", 64'(monIf.out_valid), 64'(modelLevel != 0));
      if (monIf.out_valid) begin
        if (expQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL unexpected_entry: got %0h, expected no entry", monIf.out_data);
        end else begin
          checkOutput("out_data", 64'(monIf.out_data), 64'(expQ[0].data));
          checkOutput("out_timestamp", 64'(monIf.out_timestamp), 64'(expQ[0].ts));
          if (monIf.out_ready) begin
            popLog.push_back({monIf.out_data, monIf.out_timestamp});
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] wd, input logic rdy);
    enable          = en;
    watchData       = wd;
    monIf.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic gotoCycle(input int unsigned target, input logic en, input logic [WIDTH-1:0] wd,
                           input logic rdy);
    int guard = 0;
    while (tbCycle != TS_WIDTH'(target) && guard < 2000) begin
      applyStimulus(en, wd, rdy);
      guard++;
    end
    if (guard >= 2000) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL gotoCycle: got cycle %0d, expected %0d", tbCycle, target);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " out_valid"}, 64'(monIf.out_valid), 64'(0));
    checkOutput({tag, " fifo_level"}, 64'(fifoLevel), 64'(0));
    checkOutput({tag, " overflow_count"}, 64'(overflowCount), 64'(0));
    checkOutput({tag, " out_data"}, 64'(monIf.out_data), 64'(0));
    checkOutput({tag, " out_timestamp"}, 64'(monIf.out_timestamp), 64'(0));
  endtask

  task automatic releaseReset();
    popLog.delete();
    enable          = 1'b0;
    watchData       = '0;
    monIf.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetState("async_reset");
    releaseReset();
  endtask

  task automatic checkPopData(input string name, input logic [WIDTH-1:0] want[$]);
    checkOutput({name, " count"}, 64'(popLog.size()), 64'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < popLog.size()) checkOutput({name, " data"}, 64'(popLog[i].data), 64'(want[i]));
    end
  endtask

  task automatic checkPopTs(input string name, input int idx, input logic [TS_WIDTH-1:0] want);
    if (idx < popLog.size()) checkOutput(name, 64'(popLog[idx].ts), 64'(want));
    else checkOutput({name, " present"}, 64'(popLog.size()), 64'(idx + 1));
  endtask

  initial begin : stimulus
    logic [WIDTH-1:0] want[$];
    logic             rEn;
    logic [WIDTH-1:0] rWd;
    int               readyBias;

    monIf.out_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checkResetState("powerup_reset");
    releaseReset();

    // Steady value after enabling: only the optional baseline entry may appear.
    repeat (20) applyStimulus(1'b1, 56'h234567891200, 1'b0);
`ifdef VREG_MON_FIRST_SAMPLE_EN
    checkOutput("steady level", 64'(fifoLevel), 64'(1));
    checkOutput("steady baseline", 64'(monIf.out_data), 64'(56'h234567891200));
`else
    checkOutput("steady level", 64'(fifoLevel), 64'(0));
    checkOutput("steady valid", 64'(monIf.out_valid), 64'(0));
`endif

    applyReset();
    gotoCycle(5, 1'b0, '0, 1'b1);
    gotoCycle(10, 1'b1, '0, 1'b1);
    gotoCycle(13, 1'b1, 56'h1, 1'b1);
    repeat (5) applyStimulus(1'b1, 56'h2, 1'b1);
    want.delete();
`ifdef VREG_MON_FIRST_SAMPLE_EN
    want.push_back(56'h0);
    want.push_back(56'h1);
    want.push_back(56'h2);
    checkPopData("two changes", want);
    checkPopTs("baseline ts", 0, 32'd6);
    checkPopTs("first change ts", 1, 32'd10);
    checkPopTs("second change ts", 2, 32'd13);
`else
    want.push_back(56'h1);
    want.push_back(56'h2);
    checkPopData("two changes", want);
    checkPopTs("first change ts", 0, 32'd10);
    checkPopTs("second change ts", 1, 32'd13);
`endif

    // Ten changes into an eight-deep FIFO, then a push and pop together while full.
    popLog.delete();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, WIDTH'(100 + i), 1'b0);
    checkOutput("overfill level", 64'(fifoLevel), 64'(8));
    checkOutput("overfill drops", 64'(overflowCount), 64'(2));
    applyStimulus(1'b1, WIDTH'(200), 1'b1);
    applyStimulus(1'b1, WIDTH'(200), 1'b0);
    checkOutput("full push+pop level", 64'(fifoLevel), 64'(8));
    checkOutput("full push+pop drops", 64'(overflowCount), 64'(2));
    repeat (12) applyStimulus(1'b1, WIDTH'(200), 1'b1);
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(WIDTH'(100 + i));
    want.push_back(WIDTH'(200));
    checkPopData("overfill drain", want);

    // Disabled monitor keeps its queue and ignores toggles; re-arming takes a fresh baseline.
    popLog.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'(300 + i), 1'b0);
    applyStimulus(1'b0, WIDTH'(303), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, WIDTH'(400 + i), 1'b0);
    repeat (2) applyStimulus(1'b0, WIDTH'(402), 1'b0);
    checkOutput("disabled level", 64'(fifoLevel), 64'(4));
    repeat (6) applyStimulus(1'b0, WIDTH'(402), 1'b1);
    want.delete();
    for (int i = 0; i < 4; i++) want.push_back(WIDTH'(300 + i));
    checkPopData("disabled drain", want);
    repeat (10) applyStimulus(1'b1, WIDTH'(402), 1'b0);
`ifdef VREG_MON_FIRST_SAMPLE_EN
    checkOutput("rearm level", 64'(fifoLevel), 64'(1));
`else
    checkOutput("rearm level", 64'(fifoLevel), 64'(0));
`endif
    repeat (3) applyStimulus(1'b1, WIDTH'(402), 1'b1);

    // Mid-operation reset drops pending entries and restarts the cycle count.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'(500 + i), 1'b0);
    checkOutput("pre-reset level", 64'(fifoLevel), 64'(5));
    applyReset();
    gotoCycle(4, 1'b1, '0, 1'b1);
    repeat (5) applyStimulus(1'b1, WIDTH'(7), 1'b1);
    want.delete();
`ifdef VREG_MON_FIRST_SAMPLE_EN
    want.push_back(56'h0);
    want.push_back(56'h7);
    checkPopData("after reset", want);
    checkPopTs("restart ts", 1, 32'd4);
`else
    want.push_back(56'h7);
    checkPopData("after reset", want);
    checkPopTs("restart ts", 0, 32'd4);
`endif

    for (int i = 0; i < 268; i++) applyStimulus(1'b1, WIDTH'(1000 + i), 1'b0);
    checkOutput("saturated drops", 64'(overflowCount), 64'(255));
    checkOutput("saturated level", 64'(fifoLevel), 64'(8));
    repeat (12) applyStimulus(1'b1, WIDTH'(1267), 1'b1);
    checkOutput("saturated drain level", 64'(fifoLevel), 64'(0));

    rEn       = 1'b1;
    rWd       = WIDTH'(1267);
    readyBias = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) readyBias = $urandom_range(5, 95);
      if ($urandom_range(0, 19) == 0) rEn = ~rEn;
      case ($urandom_range(0, 5))
        0: rWd = WIDTH'({$urandom(), $urandom()});
        1: rWd = WIDTH'($urandom_range(0, 3));
        default: rWd = rWd;
      endcase
      applyStimulus(rEn, rWd, $urandom_range(0, 99) < readyBias);
    end

    repeat (20) applyStimulus(1'b0, rWd, 1'b1);
    checkOutput("final level", 64'(fifoLevel), 64'(0));
    checkOutput("scoreboard empty", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
